// File: rtl/rv32i_mdu_if.sv
// Bus between the integer pipeline and the multiply/divide unit.
// One modport drives requests (master), the other returns results (slave).
interface rv32i_mdu_if #(parameter int WIDTH = 32);
  // i_start is taken only while o_busy is low. Operands and funct3 are captured on that edge.
  // o_valid pulses for one cycle, with o_result valid in that cycle. There is no back-pressure.
  // i_flush drops the in-flight operation, and no o_valid is produced for it.
  logic             i_start;
  logic             i_flush;
  logic [2:0]       i_funct3;
  logic [WIDTH-1:0] i_rs1_data;
  logic [WIDTH-1:0] i_rs2_data;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;

  modport master (
    output i_start, i_flush, i_funct3, i_rs1_data, i_rs2_data,
    input  o_busy, o_valid, o_result
  );

  modport slave (
    input  i_start, i_flush, i_funct3, i_rs1_data, i_rs2_data,
    output o_busy, o_valid, o_result
  );
endinterface

// File: rtl/rv32i_mdu.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide on magnitudes.
// Latency is fixed at 32 iterations plus one sign-correction cycle.
module rv32i_mdu #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  rv32i_mdu_if.slave  bus,
  output logic [1:0]  dbg_state
);
  localparam int W = WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [5:0]       cnt;
  logic [2:0]       op;
  logic [W-1:0]     a_raw, opnd;
  logic             b_zero, neg_q, neg_r;
  logic [2*W-1:0]   acc, acc_step;
  logic             valid_q;
  logic [W-1:0]     result_q, result_nxt;

  logic             sgn_a, sgn_b, a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag;
  logic [W:0]       mul_sum, div_shift;
  logic [W+1:0]     div_diff;
  logic [2*W-1:0]   prod_s;
  logic [W-1:0]     quo_s, rem_s;

  always_comb begin
    sgn_a = !(bus.i_funct3 == 3'b011 || bus.i_funct3 == 3'b101 || bus.i_funct3 == 3'b111);
    sgn_b = (bus.i_funct3 == 3'b000 || bus.i_funct3 == 3'b001 ||
             bus.i_funct3 == 3'b100 || bus.i_funct3 == 3'b110);
    a_neg = sgn_a & bus.i_rs1_data[W-1];
    b_neg = sgn_b & bus.i_rs2_data[W-1];
    a_mag = a_neg ? -bus.i_rs1_data : bus.i_rs1_data;
    b_mag = b_neg ? -bus.i_rs2_data : bus.i_rs2_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start) state_nxt = CALC;
      CALC:    if (cnt == 6'(W-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.i_flush) state_nxt = IDLE;
  end

  // For a multiply, acc holds {partial product, multiplier}. For a divide, it holds {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    if (!op[2])
      acc_step = {mul_sum, acc[W-1:1]};
    else if (div_diff[W+1])
      acc_step = {div_shift[W-1:0], acc[W-2:0], 1'b0};
    else
      acc_step = {div_diff[W-1:0], acc[W-2:0], 1'b1};
  end

  // Signed overflow needs no special case: 2^31 / 1 with a positive quotient sign yields 0x80000000.
  always_comb begin
    prod_s = neg_q ? -acc : acc;
    quo_s  = neg_q ? -acc[W-1:0] : acc[W-1:0];
    rem_s  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
    case (op)
      3'b000:                 result_nxt = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: result_nxt = prod_s[2*W-1:W];
      3'b100, 3'b101:         result_nxt = b_zero ? {W{1'b1}} : quo_s;
      default:                result_nxt = b_zero ? a_raw : rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      op       <= 3'd0;
      a_raw    <= '0;
      opnd     <= '0;
      acc      <= '0;
      b_zero   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state   <= state_nxt;
      valid_q <= 1'b0;
      case (state)
        IDLE: if (bus.i_start && !bus.i_flush) begin
          op     <= bus.i_funct3;
          a_raw  <= bus.i_rs1_data;
          b_zero <= (bus.i_rs2_data == '0);
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          cnt    <= 6'd0;
          opnd   <= bus.i_funct3[2] ? b_mag : a_mag;
          acc    <= {{W{1'b0}}, (bus.i_funct3[2] ? a_mag : b_mag)};
        end
        CALC: if (!bus.i_flush) begin
          acc <= acc_step;
          cnt <= cnt + 6'd1;
        end
        DONE: if (!bus.i_flush) begin
          valid_q  <= 1'b1;
          result_q <= result_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy   = (state == CALC) || (state == DONE);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign dbg_state    = state;
endmodule

// File: tb/tb_rv32i_mdu.sv
// Directed bench for rv32i_mdu: table of hand-computed operations plus
// restart, back-to-back, flush and reset sequences.
module tb_rv32i_mdu;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  rv32i_mdu_if #(.WIDTH(32)) bus ();

  rv32i_mdu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 21;
  vec_t        vecs [NV];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    @(negedge clk);
    bus.i_funct3   = f;
    bus.i_rs1_data = a;
    bus.i_rs2_data = b;
    bus.i_start    = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.i_start    = 1'b0;
    bus.i_funct3   = 3'($urandom_range(0, 7));
    bus.i_rs1_data = $urandom;
    bus.i_rs2_data = $urandom;
  endtask

  // Waits for o_valid, checks the result against the queue head, then confirms the pulse is one cycle.
  task automatic collect(input string name, input int max_edges, output int lat);
    lat = -1;
    for (int n = 1; n <= max_edges && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) lat = n;
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no o_valid within %0d edges", name, max_edges);
    end else begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: unexpected o_valid, result 0x%08h", name, bus.o_result);
      end else begin
        check({name, " result"}, bus.o_result, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      check({name, " pulse"}, {31'b0, bus.o_valid}, 32'd0);
    end
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    int v1, v2;

    vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFF9};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'd7,        32'h00000006};
    vecs[3]  = '{3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA};
    vecs[4]  = '{3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE};
    vecs[5]  = '{3'b101, 32'd20,       32'd3,        32'd6};
    vecs[6]  = '{3'b111, 32'd20,       32'd3,        32'd2};
    vecs[7]  = '{3'b101, 32'h00001234, 32'd0,        32'hFFFFFFFF};
    vecs[8]  = '{3'b110, 32'h00001234, 32'd0,        32'h00001234};
    vecs[9]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[10] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[11] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[12] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[13] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[14] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[15] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
    vecs[16] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001};
    vecs[17] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF};
    vecs[18] = '{3'b100, 32'hFFFFFFEC, 32'd0,        32'hFFFFFFFF};
    vecs[19] = '{3'b111, 32'hFFFFFFEC, 32'd0,        32'hFFFFFFEC};
    vecs[20] = '{3'b000, 32'd3,        32'd5,        32'd15};

    // Clock/reset
    rst            = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_funct3   = 3'd0;
    bus.i_rs1_data = '0;
    bus.i_rs2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",   {31'b0, bus.o_busy},  32'd0);
    check("reset valid",  {31'b0, bus.o_valid}, 32'd0);
    check("reset result", bus.o_result,         32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven operations, each with fixed 33-edge latency
    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);
      check($sformatf("vec%0d busy", i), {31'b0, bus.o_busy}, 32'd1);
      collect($sformatf("vec%0d", i), 100, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd33);
    end

    // Second start mid-CALC with new operands is ignored
    start_op(3'b010, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_funct3   = 3'b000;
    bus.i_rs1_data = 32'd3;
    bus.i_rs2_data = 32'd5;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    collect("restart", 100, lat);
    check("restart latency", 32'(lat + 10), 32'd33);
    watch_quiet("restart no second valid", 40);

    // Start held high: the DONE-edge start is dropped, the next IDLE edge accepts
    @(negedge clk);
    bus.i_funct3   = 3'b011;
    bus.i_rs1_data = 32'hFFFFFFFF;
    bus.i_rs2_data = 32'd7;
    bus.i_start    = 1'b1;
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd6);
    @(posedge clk);
    v1 = -1;
    v2 = -1;
    for (int n = 1; n <= 120 && v2 < 0; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) begin
        if (exp_q.size() != 0) check("held result", bus.o_result, exp_q.pop_front());
        if (v1 < 0) v1 = n;
        else begin
          v2 = n;
          bus.i_start = 1'b0;
        end
      end
    end
    bus.i_start = 1'b0;
    check("held first valid",  32'(v1), 32'd33);
    check("held second valid", 32'(v2), 32'd67);
    @(posedge clk);
    #1;
    check("held idle after", {31'b0, bus.o_busy}, 32'd0);
    exp_q.delete();

    // Flush at iteration 10: back to IDLE, no valid, result kept
    start_op(3'b000, 32'd12, 32'd12, 32'd0);
    void'(exp_q.pop_back());
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    check("flush busy",  {31'b0, bus.o_busy}, 32'd0);
    check("flush state", {30'b0, dbg_state},  32'd0);
    watch_quiet("flush no valid", 40);
    check("flush result kept", bus.o_result, 32'd6);
    start_op(3'b000, 32'd3, 32'd5, 32'd15);
    collect("after flush", 100, lat);
    check("after flush latency", 32'(lat), 32'd33);

    // Reset at iteration 20: everything clears, then a normal divide
    start_op(3'b101, 32'd1000, 32'd9, 32'd0);
    void'(exp_q.pop_back());
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midreset busy",   {31'b0, bus.o_busy},  32'd0);
    check("midreset valid",  {31'b0, bus.o_valid}, 32'd0);
    check("midreset result", bus.o_result,         32'd0);
    @(negedge clk);
    rst = 1'b1;
    watch_quiet("midreset no valid", 40);
    start_op(3'b101, 32'd100, 32'd7, 32'd14);
    collect("after reset", 100, lat);
    check("after reset latency", 32'(lat), 32'd33);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_mdu.md
RV32I_MDU -- requirements
Module: rv32i_mdu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_start  input  1  request to begin an M-extension operation.
REQ-005 SHALL have port i_flush  input  1  abort the in-flight operation; no result is produced.
REQ-006 SHALL have port i_funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port i_rs1_data  input  WIDTH  operand A (multiplicand or dividend).
REQ-008 SHALL have port i_rs2_data  input  WIDTH  operand B (multiplier or divisor).
REQ-009 SHALL have port o_busy  output  1  high while an operation is in progress (CALC or DONE state).
REQ-010 SHALL have port o_valid  output  1  one-cycle pulse; o_result is valid in that cycle.
REQ-011 SHALL have port o_result  output  WIDTH  result to the write-back mux.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 In IDLE, i_start=1 at a rising edge SHALL latch i_funct3, i_rs1_data and i_rs2_data, clear the iteration counter and enter CALC.
REQ-014 Operand and funct3 changes after acceptance SHALL NOT affect the in-flight result.
REQ-015 i_start SHALL be ignored in CALC and DONE; there is no queueing.
REQ-016 CALC SHALL run exactly 32 iterations using a 6-bit counter, then enter DONE; latency is fixed at 33 edges from acceptance to o_valid, whatever the operation or operand values.
REQ-017 Multiply SHALL be radix-2 shift-add on operand magnitudes into a 64-bit product; sign correction is applied in DONE.
REQ-018 Operand signedness: MUL/MULH/DIV/REM both signed; MULHSU A signed, B unsigned; MULHU/DIVU/REMU both unsigned.
REQ-019 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32] of the correctly signed 64-bit product.
REQ-020 Divide SHALL be radix-2 restoring on magnitudes; quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
REQ-021 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return the dividend unchanged.
REQ-022 Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-023 REQ-021/022 cases SHALL still take the REQ-016 latency.
REQ-024 DONE SHALL last exactly one cycle: o_valid=1 and o_result updated, then unconditional return to IDLE.
REQ-025 o_result SHALL hold its last value after DONE until the next completion.
REQ-026 i_flush=1 at a rising edge SHALL force IDLE and suppress o_valid; o_result is unchanged; flush takes priority over start and completion in the same cycle.
REQ-027 i_start sampled in the same edge as the DONE->IDLE transition SHALL be ignored; a new start is accepted only while in IDLE.
REQ-028 o_busy SHALL be combinational from state (CALC or DONE); o_valid SHALL be registered or decoded from DONE, and glitch-free.

Reset
REQ-029 rst=0 at a rising edge SHALL force IDLE, o_busy=0, o_valid=0, o_result=0, counter=0 and clear latched operands; it takes priority over i_flush and i_start.
REQ-030 Reset asserted mid-CALC SHALL abort with no o_valid pulse; the first start after release behaves as from power-up.

Verification
REQ-031 MUL A=0xFFFFFFFF (-1), B=7 -> o_valid 33 edges after start, o_result=0xFFFFFFF9; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
REQ-032 DIV A=0xFFFFFFEC (-20), B=3 -> 0xFFFFFFFA (-6); REM -> 0xFFFFFFFE (-2); DIVU A=20, B=3 -> 6; REMU -> 2.
REQ-033 DIVU A=0x1234, B=0 -> 0xFFFFFFFF; REM A=0x1234, B=0 -> 0x1234; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000, REM -> 0; each at 33-edge latency.
REQ-034 Start MULHSU A=0xFFFFFFFE, B=0x80000000; change operands and pulse i_start mid-CALC -> single o_valid, o_result=0xFFFFFFFF, second start ignored.
REQ-035 Assert i_flush at iteration 10 -> IDLE next edge, no o_valid, o_result retains prior value; then MUL 3x5 -> 15 at normal latency.
REQ-036 rst=0 at iteration 20 -> all outputs 0 next edge, no o_valid; after release, DIVU 100/7 -> 14.
